// File: rtl/regfile_dump_pkg.sv
// Shared types and sizes for the register-file dump engine.
package regfile_dump_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : regfile_dump_pkg

// File: rtl/regfile_dump.sv
// Walks register indices FIRST_REG..LAST_REG, reading each through a combinational
// register-file port and presenting it on a valid/ready stream, then pulses done.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic [REG_DATA_W-1:0] rf_data,
  output logic [REG_DATA_W-1:0] dump_data,
  output logic [REG_ADDR_W-1:0] dump_addr,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [REG_DATA_W-1:0]   data_q, data_d;
  logic [REG_ADDR_W-1:0]   daddr_q, daddr_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state and datapath; status flags are derived from the next state so they
  // come straight out of flops aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    daddr_d = daddr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = FIRST_A;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
          data_d  = rf_data;
          daddr_d = cnt_q;
        end
      end
      SEND: begin
        // abort wins over a simultaneous handshake
        if (abort) begin
          state_d = IDLE;
        end else if (dump_ready) begin
          if (cnt_q == LAST_A) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            cnt_d   = cnt_q + REG_ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == SEND);
    busy_d  = (state_d == READ) || (state_d == SEND);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      daddr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rf_addr    = cnt_q;
  assign dump_data  = data_q;
  assign dump_addr  = daddr_q;
  assign dump_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full-range instance plus a single-register instance.
module tb_regfile_dump;

  logic        clk;
  logic        rst;
  logic        start, abort, dump_ready;
  logic [4:0]  rf_addr, dump_addr;
  logic [31:0] rf_data, dump_data;
  logic        dump_valid, busy, done;

  logic        start1, abort1, dump_ready1;
  logic [4:0]  rf_addr1, dump_addr1;
  logic [31:0] rf_data1, dump_data1;
  logic        dump_valid1, busy1, done1;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] rf [32];

  int vec;
  int errs;

  regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .busy(busy), .done(done)
  );

  regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) u_one (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .rf_addr(rf_addr1), .rf_data(rf_data1),
    .dump_data(dump_data1), .dump_addr(dump_addr1), .dump_valid(dump_valid1),
    .dump_ready(dump_ready1), .busy(busy1), .done(done1)
  );

  // Register file model: reset loads reg i with i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  assign rf_data  = rf[rf_addr];
  assign rf_data1 = rf[rf_addr1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full dump on u_dut; slow=1 asserts ready one cycle in three.
  task automatic run_dump(input bit slow, input bit beef, input string tag);
    int idx;
    bit fin, hs, held;
    logic [31:0] hold_d, exp_d;
    logic [4:0]  hold_a;
    idx = 0; fin = 0; held = 0; hold_d = '0; hold_a = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if (busy !== 1'b1 || dump_valid !== 1'b0 || rf_addr !== 5'd0) begin
      errs++;
      $display("FAIL %s_start: busy=%b valid=%b rf_addr=%0d, required 1 0 0", tag, busy, dump_valid, rf_addr);
    end
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      dump_ready = slow ? (cyc % 3 == 0) : 1'b1;
      hs   = dump_valid && dump_ready;
      held = dump_valid && !dump_ready;
      tick();
      if (hs) idx++;
      if (done) begin
        fin = 1;
        vec++;
        if (idx != 32 || busy !== 1'b0 || dump_valid !== 1'b0) begin
          errs++;
          $display("FAIL %s_done: words=%0d busy=%b valid=%b, required 32 0 0", tag, idx, busy, dump_valid);
        end
        if (!slow) begin
          vec++;
          if (cyc != 64) begin
            errs++;
            $display("FAIL %s_latency: done after %0d edges, required 64", tag, cyc);
          end
        end
      end else begin
        if (held) begin
          vec++;
          if (dump_valid !== 1'b1 || dump_data !== hold_d || dump_addr !== hold_a) begin
            errs++;
            $display("FAIL %s_hold: valid=%b addr=%0d data=%h, required 1 %0d %h", tag, dump_valid, dump_addr, dump_data, hold_a, hold_d);
          end
        end
        if (dump_valid) begin
          exp_d = (beef && idx == 7) ? 32'hDEADBEEF : 32'(idx);
          vec++;
          if (dump_addr !== 5'(idx) || dump_data !== exp_d) begin
            errs++;
            $display("FAIL %s_word: addr=%0d data=%h, required %0d %h", tag, dump_addr, dump_data, idx, exp_d);
          end
          hold_d = dump_data;
          hold_a = dump_addr;
        end
      end
    end
    vec++;
    if (!fin) begin
      errs++;
      $display("FAIL %s_timeout: done=%b, required 1 within 400 cycles", tag, done);
    end
    tick();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0 || dump_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s_after: done=%b busy=%b valid=%b, required 0 0 0", tag, done, busy, dump_valid);
    end
    dump_ready = 1'b0;
  endtask

  // Step u_dut with ready=1 until word `target` is presented; returns 0 on timeout.
  task automatic run_to_word(input logic [4:0] target, output bit ok);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (dump_valid && dump_addr == target) begin
        ok = 1;
        break;
      end
      dump_ready = 1'b1;
      tick();
    end
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL reach_word: word %0d not presented, valid=%b addr=%0d", target, dump_valid, dump_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; dump_ready = 0;
    start1 = 0; abort1 = 0; dump_ready1 = 0;
    rf_we = 0; rf_wa = '0; rf_wd = '0;
    #2 rst = 1'b0;
    #1;
    vec++;
    if (busy !== 0 || done !== 0 || dump_valid !== 0 || dump_data !== 32'd0 || dump_addr !== 5'd0 || rf_addr !== 5'd0) begin
      errs++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b data=%h addr=%0d rf_addr=%0d, required all 0", busy, done, dump_valid, dump_data, dump_addr, rf_addr);
    end
    vec++;
    if (busy1 !== 0 || dump_valid1 !== 0 || rf_addr1 !== 5'd0) begin
      errs++;
      $display("FAIL reset_one: busy=%b valid=%b rf_addr=%0d, required 0 0 0", busy1, dump_valid1, rf_addr1);
    end
    repeat (2) tick();
    // start presented together with reset release is honoured at the first edge
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if (busy !== 1 || rf_addr !== 5'd0 || dump_valid !== 0) begin
      errs++;
      $display("FAIL first_start: busy=%b rf_addr=%0d valid=%b, required 1 0 0", busy, rf_addr, dump_valid);
    end
    tick();
    vec++;
    if (dump_valid !== 1 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      errs++;
      $display("FAIL first_word: valid=%b addr=%0d data=%h, required 1 0 0", dump_valid, dump_addr, dump_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec++;
    if (dump_valid !== 0 || busy !== 0 || done !== 0) begin
      errs++;
      $display("FAIL first_abort: valid=%b busy=%b done=%b, required 0 0 0", dump_valid, busy, done);
    end
  endtask

  task automatic test_full_dump();
    run_dump(1'b0, 1'b0, "full");
  endtask

  task automatic test_backpressure();
    run_dump(1'b1, 1'b0, "slow");
  endtask

  task automatic test_write_during_send();
    bit ok, fin;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_word(5'd7, ok);
    dump_ready = 1'b0;
    rf_we = 1'b1; rf_wa = 5'd7; rf_wd = 32'hDEADBEEF;
    tick();
    rf_we = 1'b0;
    tick();
    vec++;
    if (dump_valid !== 1 || dump_addr !== 5'd7 || dump_data !== 32'd7) begin
      errs++;
      $display("FAIL held_after_write: valid=%b addr=%0d data=%h, required 1 7 00000007", dump_valid, dump_addr, dump_data);
    end
    fin = 0;
    dump_ready = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      tick();
      fin = done;
    end
    vec++;
    if (!fin) begin
      errs++;
      $display("FAIL write_drain: done=%b, required 1", done);
    end
    tick();
    dump_ready = 1'b0;
    run_dump(1'b0, 1'b1, "beef");
  endtask

  task automatic test_abort();
    bit ok;
    int bad;
    // start stays high throughout; it must not restart an active dump
    start = 1'b1;
    tick();
    run_to_word(5'd10, ok);
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_pre: busy=%b, required 1", busy);
    end
    abort = 1'b1; start = 1'b0; dump_ready = 1'b1;
    tick();
    abort = 1'b0;
    vec++;
    if (dump_valid !== 0 || busy !== 0 || done !== 0) begin
      errs++;
      $display("FAIL abort_idle: valid=%b busy=%b done=%b, required 0 0 0", dump_valid, busy, done);
    end
    bad = 0;
    repeat (6) begin
      tick();
      if (dump_valid || busy || done) bad++;
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
    end
    dump_ready = 1'b0;
  endtask

  task automatic test_single_reg();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vec++;
    if (busy1 !== 1 || rf_addr1 !== 5'd5) begin
      errs++;
      $display("FAIL single_read: busy=%b rf_addr=%0d, required 1 5", busy1, rf_addr1);
    end
    tick();
    vec++;
    if (dump_valid1 !== 1 || dump_addr1 !== 5'd5 || dump_data1 !== 32'd5) begin
      errs++;
      $display("FAIL single_word: valid=%b addr=%0d data=%h, required 1 5 5", dump_valid1, dump_addr1, dump_data1);
    end
    dump_ready1 = 1'b1;
    tick();
    dump_ready1 = 1'b0;
    vec++;
    if (done1 !== 1 || busy1 !== 0 || dump_valid1 !== 0) begin
      errs++;
      $display("FAIL single_done: done=%b busy=%b valid=%b, required 1 0 0", done1, busy1, dump_valid1);
    end
    tick();
    vec++;
    if (done1 !== 0 || busy1 !== 0 || dump_valid1 !== 0) begin
      errs++;
      $display("FAIL single_idle: done=%b busy=%b valid=%b, required 0 0 0", done1, busy1, dump_valid1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_word(5'd20, ok);
    #2 rst = 1'b0;
    #1;
    vec++;
    if (busy !== 0 || done !== 0 || dump_valid !== 0 || dump_data !== 32'd0 || dump_addr !== 5'd0 || rf_addr !== 5'd0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b done=%b valid=%b data=%h addr=%0d rf_addr=%0d, required all 0", busy, done, dump_valid, dump_data, dump_addr, rf_addr);
    end
    tick();
    #3 rst = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (dump_valid || busy || done) bad++;
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL post_reset_idle: %0d active cycles without start, required 0", bad);
    end
    dump_ready = 1'b0;
    run_dump(1'b0, 1'b0, "restart");
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_write_during_send();
    test_abort();
    test_single_reg();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule : tb_regfile_dump

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter: FIRST_REG, 0, first register index dumped (0..31).
REQ-002 Parameter: LAST_REG, 31, last register index dumped (FIRST_REG..31).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 Port: start  input  1  request a dump; sampled only in IDLE.
REQ-006 Port: abort  input  1  synchronous cancel of a dump in progress.
REQ-007 Port: rf_addr  output  5  register-file read address; drives a combinational read port.
REQ-008 Port: rf_data  input  32  register-file read data for rf_addr, same cycle.
REQ-009 Port: dump_data  output  32  captured register value.
REQ-010 Port: dump_addr  output  5  register index of dump_data.
REQ-011 Port: dump_valid  output  1  dump_data/dump_addr valid.
REQ-012 Port: dump_ready  input  1  consumer accepts the word when high with dump_valid.
REQ-013 Port: busy  output  1  high in READ and SEND.
REQ-014 Port: done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 FSM states SHALL be IDLE, READ, SEND, DONE; outputs registered or decoded from state only.
REQ-016 IDLE: start=1 at an edge -> READ, address counter loaded with FIRST_REG.
REQ-017 rf_addr SHALL equal the address counter in every state.
REQ-018 READ: at the next edge rf_data captured into dump_data, counter into dump_addr, -> SEND.
REQ-019 SEND: dump_valid=1; dump_data/dump_addr SHALL stay stable until dump_valid&dump_ready at an edge.
REQ-020 On handshake with counter!=LAST_REG: counter+1, -> READ; with counter==LAST_REG: -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, busy=0, then -> IDLE unconditionally.
REQ-022 Minimum throughput 2 cycles/word; start at edge k -> dump_valid first high after edge k+1.
REQ-023 Counter SHALL never wrap: the dump ends at LAST_REG; FIRST_REG==LAST_REG dumps exactly one word.
REQ-024 start while busy or in DONE SHALL be ignored (no queuing).
REQ-025 abort=1 in READ or SEND -> IDLE at next edge, dump_valid=0, no done pulse; abort has priority over handshake; ignored in IDLE/DONE.
REQ-026 Value dumped SHALL be rf_data as sampled at the READ->SEND edge; later register writes do not alter a held word.
REQ-027 dump_valid SHALL be 0 in IDLE, READ, DONE.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE and counter, rf_addr, dump_data, dump_addr to 0, dump_valid, busy, done to 0.
REQ-029 Reset mid-dump SHALL abandon the dump with no done pulse; a new start is required after release.
REQ-030 First start SHALL be honoured at the first rising edge with rst=1.

Structure
REQ-031 Shared package SHALL hold the state enumeration, REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
REQ-032 Single flat module, no sub-module; the register file is instantiated alongside it only in the bench.

Verification
REQ-033 Register file reset-loaded so reg i holds i; start pulse, dump_ready=1 -> 32 words, dump_addr=dump_data=0..31 in order, done once, 64 cycles start-to-done edge.
REQ-034 Same, dump_ready toggled 1-of-3 cycles -> same 32 words, each held stable while dump_valid=1 and ready=0, no drop/duplicate.
REQ-035 FIRST_REG=5, LAST_REG=5 -> single word addr 5 data 5, done pulse, back to IDLE.
REQ-036 Write 0xDEADBEEF to reg 7 while word 7 held in SEND -> dump_data stays 7; restart dump -> word 7 = 0xDEADBEEF.
REQ-037 abort in SEND of word 10 -> IDLE next cycle, no done, no further words; start during busy ignored.
REQ-038 rst=0 asserted mid-cycle during word 20 -> outputs zero immediately without a clock edge; after release, new start dumps from FIRST_REG.
